serial_mul: RTL and testbench

Sequential shift-and-add fixed-point multiplier with independent valid/ready handshakes on each operand and on the result. It accepts one `width`-bit operand on `x` and one on `y`, in any order. It then computes the full `2*width`-bit product in `width` iterations, one multiplier bit per clock, and holds the result until the consumer accepts it. It sits in the serial fixed-point datapath between the operand producers and downstream accumulate/scale stages.

---
 rtl/serial_mul.sv | 145 ++++++++++++++
 tb/tb_serial_mul.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_mul.sv
// Serial shift-and-add multiplier: width x width -> 2*width, one multiplier bit per clock.
// Latency: d_out_vld rises width edges after the edge capturing the later operand.
// Backpressure: result held in DONE until d_out_rdy; operands refused outside IDLE. Option: SERIAL_MUL_SIGNED_EN.
module serial_mul #(
   parameter int width = 8
) (
   input  logic                 clk,
   input  logic                 asyn_reset,
   input  logic [width-1:0]     x,
   input  logic [width-1:0]     y,
   input  logic                 data_x_vld,
   output logic                 data_x_rdy,
   input  logic                 data_y_vld,
   output logic                 data_y_rdy,
   output logic [2*width-1:0]   product,
   output logic                 d_out_vld,
   input  logic                 d_out_rdy
);

   localparam int CW = (width > 1) ? $clog2(width) : 1;
   localparam logic [CW-1:0] LAST = CW'(width - 1);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t               state;
   state_t               state_next;
   logic                 x_got;
   logic                 y_got;
   logic [width-1:0]     x_reg;
   logic [width-1:0]     y_reg;
   logic [2*width-1:0]   acc;
   logic [2*width-1:0]   acc_next;
   logic [2*width-1:0]   mcand_ext;
   logic [2*width-1:0]   partial;
   logic [CW-1:0]        cnt;
   logic                 last_iter;
   logic                 x_fire;
   logic                 y_fire;

   assign x_fire    = data_x_vld && data_x_rdy;
   assign y_fire    = data_y_vld && data_y_rdy;
   assign last_iter = (cnt == LAST);

   // State register
   always_ff @(posedge clk) begin
      if (asyn_reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state and handshake outputs; ready/valid decode only registered state
   always_comb begin
      state_next = state;
      data_x_rdy = 1'b0;
      data_y_rdy = 1'b0;
      d_out_vld  = 1'b0;
      case (state)
         IDLE: begin
            data_x_rdy = !x_got;
            data_y_rdy = !y_got;
            // An operand counts as held if already captured or captured on this edge
            if ((x_got || data_x_vld) && (y_got || data_y_vld)) begin
               state_next = BUSY;
            end
         end
         BUSY: begin
            if (last_iter) begin
               state_next = DONE;
            end
         end
         DONE: begin
            d_out_vld = 1'b1;
            if (d_out_rdy) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // One shift-and-add step; the MSB step subtracts in two's complement mode
   always_comb begin
`ifdef SERIAL_MUL_SIGNED_EN
      mcand_ext = {{width{x_reg[width-1]}}, x_reg};
`else
      mcand_ext = {{width{1'b0}}, x_reg};
`endif
      partial  = mcand_ext << cnt;
      acc_next = acc;
      if (y_reg[cnt]) begin
`ifdef SERIAL_MUL_SIGNED_EN
         if (last_iter) begin
            acc_next = acc - partial;
         end else begin
            acc_next = acc + partial;
         end
`else
         acc_next = acc + partial;
`endif
      end
   end

   // Operand capture, iteration and result registers
   always_ff @(posedge clk) begin
      if (asyn_reset) begin
         x_got   <= 1'b0;
         y_got   <= 1'b0;
         x_reg   <= '0;
         y_reg   <= '0;
         acc     <= '0;
         cnt     <= '0;
         product <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (x_fire) begin
                  x_reg <= x;
                  x_got <= 1'b1;
               end
               if (y_fire) begin
                  y_reg <= y;
                  y_got <= 1'b1;
               end
               if (state_next == BUSY) begin
                  x_got <= 1'b0;
                  y_got <= 1'b0;
                  acc   <= '0;
                  cnt   <= '0;
               end
            end
            BUSY: begin
               acc <= acc_next;
               cnt <= cnt + CW'(1);
               if (last_iter) begin
                  product <= acc_next;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_mul.sv
module tb_serial_mul;

   localparam int W = 8;

   logic            clk = 1'b0;
   logic            asyn_reset;
   logic [W-1:0]    x;
   logic [W-1:0]    y;
   logic            data_x_vld;
   logic            data_x_rdy;
   logic            data_y_vld;
   logic            data_y_rdy;
   logic [2*W-1:0]  product;
   logic            d_out_vld;
   logic            d_out_rdy;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   serial_mul #(.width(W)) dut (
      .clk        (clk),
      .asyn_reset (asyn_reset),
      .x          (x),
      .y          (y),
      .data_x_vld (data_x_vld),
      .data_x_rdy (data_x_rdy),
      .data_y_vld (data_y_vld),
      .data_y_rdy (data_y_rdy),
      .product    (product),
      .d_out_vld  (d_out_vld),
      .d_out_rdy  (d_out_rdy)
   );

   // Reference: plain integer multiplication in the configured number format
   function automatic logic [2*W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
      int p;
`ifdef SERIAL_MUL_SIGNED_EN
      p = int'($signed(a)) * int'($signed(b));
`else
      p = int'(a) * int'(b);
`endif
      return p[2*W-1:0];
   endfunction

   // Present both operands together, then count rising edges until a result appears
   task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b,
                           output int lat, output bit timeout);
      @(negedge clk);
      x = a; y = b; data_x_vld = 1'b1; data_y_vld = 1'b1;
      @(posedge clk);
      @(negedge clk);
      data_x_vld = 1'b0; data_y_vld = 1'b0;
      lat = 0;
      timeout = 1'b1;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
         if (d_out_vld) begin
            timeout = 1'b0;
            break;
         end
      end
   endtask

   task automatic accept();
      d_out_rdy = 1'b1;
      @(posedge clk);
      @(negedge clk);
      d_out_rdy = 1'b0;
   endtask

   task automatic test_reset();
      asyn_reset = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      asyn_reset = 1'b0;
      checks++; if (product !== 16'h0000) begin errors++; $display("FAIL reset_product: got %h expected 0000", product); end
      checks++; if (d_out_vld !== 1'b0) begin errors++; $display("FAIL reset_vld: got %b expected 0", d_out_vld); end
      checks++; if (data_x_rdy !== 1'b1) begin errors++; $display("FAIL reset_x_rdy: got %b expected 1", data_x_rdy); end
      checks++; if (data_y_rdy !== 1'b1) begin errors++; $display("FAIL reset_y_rdy: got %b expected 1", data_y_rdy); end
   endtask

   task automatic test_basic();
      logic [W-1:0] av[2];
      logic [W-1:0] bv[2];
      int lat;
      bit to;
      av[0] = 8'd3;   bv[0] = 8'd5;
      av[1] = 8'd255; bv[1] = 8'd255;
      for (int i = 0; i < 2; i++) begin
         start_op(av[i], bv[i], lat, to);
         checks++; if (to) begin errors++; $display("FAIL basic_timeout[%0d]: no d_out_vld within 40 edges", i); end
         checks++; if (lat != W) begin errors++; $display("FAIL basic_latency[%0d]: got %0d expected %0d", i, lat, W); end
         checks++; if (product !== model(av[i], bv[i])) begin errors++; $display("FAIL basic_product[%0d]: got %h expected %h", i, product, model(av[i], bv[i])); end
         accept();
      end
      checks++; if (product !== model(av[1], bv[1])) begin errors++; $display("FAIL basic_hold_after_accept: got %h expected %h", product, model(av[1], bv[1])); end
   endtask

   task automatic test_staggered();
      int lat;
      bit to;
      @(negedge clk);
      x = 8'h10; data_x_vld = 1'b1;
      @(posedge clk);
      @(negedge clk);
      data_x_vld = 1'b0;
      x = 8'hff;  // captured value must not follow later changes
      for (int c = 1; c <= 4; c++) begin
         checks++; if (data_x_rdy !== 1'b0) begin errors++; $display("FAIL stag_x_rdy[%0d]: got %b expected 0", c, data_x_rdy); end
         checks++; if (data_y_rdy !== 1'b1) begin errors++; $display("FAIL stag_y_rdy[%0d]: got %b expected 1", c, data_y_rdy); end
         if (c < 4) begin
            @(posedge clk);
            @(negedge clk);
         end
      end
      y = 8'h20; data_y_vld = 1'b1;
      @(posedge clk);
      @(negedge clk);
      data_y_vld = 1'b0;
      lat = 0;
      to = 1'b1;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
         if (d_out_vld) begin to = 1'b0; break; end
      end
      checks++; if (to || lat != W) begin errors++; $display("FAIL stag_latency: got %0d expected %0d", lat, W); end
      checks++; if (product !== 16'h0200) begin errors++; $display("FAIL stag_product: got %h expected 0200", product); end
      accept();
   endtask

   task automatic test_backpressure();
      logic [2*W-1:0] snap;
      int lat;
      bit to;
      start_op(8'd200, 8'd13, lat, to);
      snap = model(8'd200, 8'd13);
      checks++; if (to || product !== snap) begin errors++; $display("FAIL bp_product: got %h expected %h", product, snap); end
      for (int c = 0; c < 5; c++) begin
         @(posedge clk);
         @(negedge clk);
         checks++; if (d_out_vld !== 1'b1 || product !== snap) begin errors++; $display("FAIL bp_hold[%0d]: vld=%b product=%h expected vld=1 product=%h", c, d_out_vld, product, snap); end
         checks++; if (data_x_rdy !== 1'b0 || data_y_rdy !== 1'b0) begin errors++; $display("FAIL bp_rdy[%0d]: got %b%b expected 00", c, data_x_rdy, data_y_rdy); end
      end
      accept();
      checks++; if (d_out_vld !== 1'b0) begin errors++; $display("FAIL bp_accept_vld: got %b expected 0", d_out_vld); end
      checks++; if (data_x_rdy !== 1'b1 || data_y_rdy !== 1'b1) begin errors++; $display("FAIL bp_accept_rdy: got %b%b expected 11", data_x_rdy, data_y_rdy); end
   endtask

   task automatic test_reset_mid();
      int lat;
      bit to;
      @(negedge clk);
      x = 8'd7; y = 8'd9; data_x_vld = 1'b1; data_y_vld = 1'b1;
      @(posedge clk);
      @(negedge clk);
      data_x_vld = 1'b0; data_y_vld = 1'b0;
      repeat (4) @(posedge clk);
      @(negedge clk);
      asyn_reset = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      asyn_reset = 1'b0;
      checks++; if (product !== 16'h0000) begin errors++; $display("FAIL mid_reset_product: got %h expected 0000", product); end
      checks++; if (d_out_vld !== 1'b0) begin errors++; $display("FAIL mid_reset_vld: got %b expected 0", d_out_vld); end
      checks++; if (data_x_rdy !== 1'b1 || data_y_rdy !== 1'b1) begin errors++; $display("FAIL mid_reset_rdy: got %b%b expected 11", data_x_rdy, data_y_rdy); end
      start_op(8'd2, 8'd2, lat, to);
      checks++; if (to || lat != W) begin errors++; $display("FAIL mid_reset_latency: got %0d expected %0d", lat, W); end
      checks++; if (product !== 16'h0004) begin errors++; $display("FAIL mid_reset_product_after: got %h expected 0004", product); end
      accept();
   endtask

   task automatic test_random();
      logic [W-1:0] a;
      logic [W-1:0] b;
      int lat;
      int hold;
      bit to;
      for (int n = 0; n < 16; n++) begin
         a = W'($urandom);
         b = W'($urandom);
         hold = $urandom_range(0, 3);
         start_op(a, b, lat, to);
         checks++; if (to || lat != W) begin errors++; $display("FAIL rand_latency[%0d]: got %0d expected %0d", n, lat, W); end
         checks++; if (product !== model(a, b)) begin errors++; $display("FAIL rand_product[%0d] %h*%h: got %h expected %h", n, a, b, product, model(a, b)); end
         repeat (hold) begin
            @(posedge clk);
            @(negedge clk);
         end
         accept();
      end
   endtask

   task automatic test_back_to_back();
      logic [W-1:0] xa[4];
      logic [W-1:0] ya[4];
      int idx;
      int nres;
      int last_cyc;
      bit adv;
      for (int i = 0; i < 4; i++) begin
         xa[i] = W'($urandom);
         ya[i] = W'($urandom);
      end
      idx = 0; nres = 0; last_cyc = -1; adv = 1'b0;
      @(negedge clk);
      x = xa[0]; y = ya[0]; data_x_vld = 1'b1; data_y_vld = 1'b1; d_out_rdy = 1'b1;
      for (int c = 0; c < 80 && nres < 4; c++) begin
         if (data_x_rdy && data_y_rdy && data_x_vld && data_y_vld) adv = 1'b1;
         @(posedge clk);
         @(negedge clk);
         if (adv) begin
            adv = 1'b0;
            idx++;
            if (idx < 4) begin
               x = xa[idx]; y = ya[idx];
            end else begin
               data_x_vld = 1'b0; data_y_vld = 1'b0;
            end
         end
         if (d_out_vld) begin
            checks++; if (product !== model(xa[nres], ya[nres])) begin errors++; $display("FAIL b2b_product[%0d]: got %h expected %h", nres, product, model(xa[nres], ya[nres])); end
            if (nres > 0) begin
               checks++; if (c - last_cyc != W + 2) begin errors++; $display("FAIL b2b_interval[%0d]: got %0d expected %0d", nres, c - last_cyc, W + 2); end
            end
            last_cyc = c;
            nres++;
         end
      end
      checks++; if (nres != 4) begin errors++; $display("FAIL b2b_count: got %0d expected 4", nres); end
      data_x_vld = 1'b0; data_y_vld = 1'b0; d_out_rdy = 1'b0;
      @(posedge clk);
      @(negedge clk);
   endtask

`ifdef SERIAL_MUL_SIGNED_EN
   task automatic test_signed();
      logic [W-1:0]   av[4];
      logic [W-1:0]   bv[4];
      logic [2*W-1:0] ev[4];
      int lat;
      bit to;
      av[0] = 8'hff; bv[0] = 8'hff; ev[0] = 16'h0001;
      av[1] = 8'h80; bv[1] = 8'h7f; ev[1] = 16'hc080;
      av[2] = 8'h80; bv[2] = 8'h80; ev[2] = 16'h4000;
      av[3] = 8'h05; bv[3] = 8'hfd; ev[3] = 16'hfff1;
      for (int i = 0; i < 4; i++) begin
         start_op(av[i], bv[i], lat, to);
         checks++; if (to || product !== ev[i]) begin errors++; $display("FAIL signed_product[%0d]: got %h expected %h", i, product, ev[i]); end
         accept();
      end
   endtask
`endif

   initial begin
      asyn_reset = 1'b1;
      x = '0; y = '0;
      data_x_vld = 1'b0; data_y_vld = 1'b0; d_out_rdy = 1'b0;
      test_reset();
      test_basic();
      test_staggered();
      test_backpressure();
      test_reset_mid();
      test_random();
      test_back_to_back();
`ifdef SERIAL_MUL_SIGNED_EN
      test_signed();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
